// File: rtl/alu_pkg.sv
// Shared opcode, width and state definitions for the ALU arbiter slice.
package alu_pkg;

  localparam int OPW = 4;
  localparam int DW  = 32;
  localparam logic [DW-1:0] ZERO = '0;

  localparam logic [OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB = 4'b0010;
  localparam logic [OPW-1:0] OP_AND = 4'b0100;
  localparam logic [OPW-1:0] OP_OR  = 4'b0101;
  localparam logic [OPW-1:0] OP_XOR = 4'b0110;
  localparam logic [OPW-1:0] OP_NOR = 4'b0111;
  localparam logic [OPW-1:0] OP_SLT = 4'b1010;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT: is_legal_op = 1'b1;
      default:                                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int             sum;
  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IDW'(sum);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NREQ requesters, one op in flight,
// returning each result on a single response channel tagged with the requester id.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [OPW-1:0]    alu_opin,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [DW-1:0]     rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t          state, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [OPW-1:0]  op_q;
  logic [DW-1:0]   a_q, b_q;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt;
  logic [OPW-1:0]  sel_op;
  logic [DW-1:0]   sel_a, sel_b;
  logic            legal;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign sel_op = req_op[int'(grant_idx)*OPW +: OPW];
  assign sel_a  = req_a[int'(grant_idx)*DW +: DW];
  assign sel_b  = req_b[int'(grant_idx)*DW +: DW];
  assign legal  = is_legal_op(sel_op);

  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Illegal ops skip the ALU entirely and answer straight from IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant_any) state_d = legal ? ISSUE : RESP;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= IDW'(NREQ - 1);
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      cnt        <= '0;
      alu_opin   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= ZERO;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= grant_idx;
            rr_ptr <= grant_idx;
            if (!legal) begin
              rsp_result <= ZERO;
              rsp_zero   <= 1'b1;
              rsp_err    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          alu_opin <= op_q;
          alu_a    <= a_q;
          alu_b    <= b_q;
          cnt      <= CW'(ALU_LAT - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_zero   <= (alu_result == ZERO);
            rsp_err    <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are queued at accept and
// compared at the response handshake, with directed checks around them.
module tb_alu_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int ALU_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [3:0]        alu_opin;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_zero, rsp_err, busy;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } res_t;

  typedef struct {
    int   id;
    res_t r;
  } sb_t;

  sb_t             sb[$];
  int              grant_log[$];
  int              errors = 0;
  int              checks = 0;
  int              rsp_count = 0;
  int              tb_ptr = NREQ - 1;
  logic [NREQ-1:0] sticky;
  res_t            alu_model;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW), .ALU_LAT(ALU_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_opin   (alu_opin),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  function automatic res_t refOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    r.err    = 1'b0;
    r.result = 32'd0;
    case (op)
      4'b0000: r.result = a + b;
      4'b0010: r.result = a - b;
      4'b0100: r.result = a & b;
      4'b0101: r.result = a | b;
      4'b0110: r.result = a ^ b;
      4'b0111: r.result = ~(a | b);
      4'b1010: r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    r.zero = (r.result == 32'd0);
    return r;
  endfunction

  // The external ALU: combinational on its held inputs, stable through WAIT.
  always_comb alu_model = refOp(alu_opin, alu_a, alu_b);
  assign alu_result = alu_model.result;

  function automatic int rrPick(input logic [NREQ-1:0] v, input int ptr);
    for (int n = 0; n < NREQ; n++) begin
      int c = (ptr + 1 + n) % NREQ;
      if (v[IDW'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic int lastGrant();
    if (grant_log.size() == 0) return -1;
    return grant_log[grant_log.size()-1];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic hold);
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    sticky[IDW'(i)]    = hold;
    req_valid[IDW'(i)] = 1'b1;
  endtask

  // One clock: observe accepts and responses at the falling edge, then step past the rising edge.
  task automatic tick();
    int   g;
    int   clr;
    sb_t  e;
    clr = -1;
    @(negedge clk);
    if (req_ready != '0) begin
      g = rrPick(req_valid, tb_ptr);
      if (g < 0) begin
        checkOutput("grant_none", 32'(req_ready), 32'd0);
      end else begin
        checkOutput("grant", 32'(req_ready), 32'd1 << g);
        e.id = g;
        e.r  = refOp(req_op[4*g +: 4], req_a[32*g +: 32], req_b[32*g +: 32]);
        sb.push_back(e);
        tb_ptr = g;
        grant_log.push_back(g);
        if (!sticky[IDW'(g)]) clr = g;
      end
    end
    if (rsp_valid && rsp_ready) begin
      rsp_count++;
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("rsp_result", rsp_result, e.r.result);
        checkOutput("rsp_zero", 32'(rsp_zero), 32'(e.r.zero));
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.r.err));
      end
    end
    @(posedge clk);
    #1;
    if (clr >= 0) req_valid[IDW'(clr)] = 1'b0;
  endtask

  task automatic waitRsp(input int n);
    int goal;
    goal = rsp_count + n;
    for (int t = 0; t < 200 && rsp_count < goal; t++) tick();
    checkOutput("rsp_count", 32'(rsp_count), 32'(goal));
  endtask

  task automatic waitGrants(input int n);
    for (int t = 0; t < 400 && grant_log.size() < n; t++) tick();
    checkOutput("grant_count", 32'(grant_log.size()), 32'(n));
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) tick();
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    req_valid = '0;
    sticky    = '0;
    sb.delete();
    grant_log.delete();
    tb_ptr = NREQ - 1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_rr [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    int got;

    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    sticky    = '0;

    #2;
    checkOutput("reset_ctrl", 32'({req_ready, alu_opin, rsp_valid, rsp_id, rsp_zero, rsp_err, busy}), 32'd0);
    checkOutput("reset_alu_a", alu_a, 32'd0);
    checkOutput("reset_alu_b", alu_b, 32'd0);
    checkOutput("reset_rsp_result", rsp_result, 32'd0);
    tick();
    reset = 1'b0;

    $display("[TB] single ADD from requester 0");
    applyStimulus(0, 4'b0000, 32'd5, 32'd7, 1'b0);
    tick();
    checkOutput("add_grant", 32'(lastGrant()), 32'd0);
    checkOutput("add_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("add_alu_op", 32'(alu_opin), 32'd0);
    checkOutput("add_alu_a", alu_a, 32'd5);
    checkOutput("add_alu_b", alu_b, 32'd7);
    tick();
    checkOutput("add_alu_a_held", alu_a, 32'd5);
    checkOutput("add_alu_b_held", alu_b, 32'd7);
    tick();
    checkOutput("add_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("add_rsp_result", rsp_result, 32'd12);
    waitRsp(1);

    $display("[TB] SUB to zero from requester 2");
    applyStimulus(2, 4'b0010, 32'h1234, 32'h1234, 1'b0);
    waitRsp(1);
    checkOutput("sub_grant", 32'(lastGrant()), 32'd2);

    $display("[TB] round robin with all requesters valid");
    doReset();
    applyStimulus(0, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    applyStimulus(1, 4'b0101, 32'h0000_0001, 32'h0000_0100, 1'b1);
    applyStimulus(2, 4'b0110, 32'h0000_AAAA, 32'h0000_5555, 1'b1);
    applyStimulus(3, 4'b1010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    waitGrants(5);
    req_valid[1] = 1'b0;
    sticky[1]    = 1'b0;
    waitGrants(9);
    req_valid = '0;
    sticky    = '0;
    for (int i = 0; i < 9; i++) begin
      got = (i < grant_log.size()) ? grant_log[i] : -1;
      checkOutput("rr_order", 32'(got), 32'(exp_rr[i]));
    end
    drain();

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1, 4'b0111, 32'h0F0F_0000, 32'h0000_00F0, 1'b0);
    for (int t = 0; t < 20 && !rsp_valid; t++) tick();
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    applyStimulus(3, 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int t = 0; t < 5; t++) begin
      tick();
      checkOutput("bp_hold_ctrl", 32'({rsp_valid, rsp_id, rsp_zero, rsp_err, busy, req_ready}),
                  32'({1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000}));
      checkOutput("bp_hold_result", rsp_result, 32'hF0F0_FF0F);
    end
    rsp_ready = 1'b1;
    checkOutput("bp_no_grant_at_handshake", 32'(req_ready), 32'd0);
    tick();
    checkOutput("bp_next_grant", 32'(req_ready), 32'b1000);
    checkOutput("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    waitRsp(1);

    $display("[TB] illegal opcode from requester 3");
    applyStimulus(3, 4'b1111, 32'd9, 32'd9, 1'b0);
    tick();
    checkOutput("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("ill_rsp_id", 32'(rsp_id), 32'd3);
    checkOutput("ill_alu_op_kept", 32'(alu_opin), 32'b0110);
    checkOutput("ill_alu_a_kept", alu_a, 32'hFFFF_FFFF);
    waitRsp(1);

    $display("[TB] reset during WAIT");
    applyStimulus(1, 4'b0000, 32'd1, 32'd2, 1'b0);
    tick();
    tick();
    checkOutput("mid_alu_a", alu_a, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_ctrl", 32'({req_ready, alu_opin, rsp_valid, rsp_id, rsp_zero, rsp_err, busy}), 32'd0);
    checkOutput("mid_reset_alu_a", alu_a, 32'd0);
    checkOutput("mid_reset_alu_b", alu_b, 32'd0);
    checkOutput("mid_reset_result", rsp_result, 32'd0);
    sb.delete();
    grant_log.delete();
    tb_ptr = NREQ - 1;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checkOutput("post_reset_quiet", 32'({rsp_valid, busy}), 32'd0);
    end
    applyStimulus(2, 4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0);
    applyStimulus(0, 4'b0101, 32'h0000_0000, 32'h0000_0000, 1'b0);
    tick();
    checkOutput("post_reset_first_grant", 32'(lastGrant()), 32'd0);
    waitRsp(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
